// File: rtl/sudoku_disp_pkg.sv
// Shared constants and types for the Sudoku seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sudoku_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Index 0 is the empty-cell value and decodes to blank.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // D
    7'b1000110,  // C
    7'b0000011,  // B
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    SEG_BLANK    // 0
  };

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational 4-bit to active-low seven-segment decoder; value 0 is blank.
module hex_to_sevenseg
  import sudoku_disp_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_LUT[val_i];
  end

endmodule

// File: rtl/sevenseg_display_driver.sv
// Multiplexed 4-digit common-anode display driver with cursor blink and error LED stretch.
// Optional macro DISPLAY_DP_CURSOR_EN lights the decimal point on the cursor digit.
module sevenseg_display_driver
  import sudoku_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned ERR_HOLD  = 25000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] currentRow,
  input  logic [3:0]  currentNum,
  input  logic        noWrite,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        errLed
);

  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  // Sized to hold ERR_HOLD itself, including power-of-two values.
  localparam int unsigned ErrW   = $clog2(ERR_HOLD + 1);

  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [ErrW-1:0]   ErrLoad   = ErrW'(ERR_HOLD);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  digit_idx_t        dig_idx_q, dig_idx_d;
  logic [ErrW-1:0]   err_cnt_q, err_cnt_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       err_led_q, err_led_d;

  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic       cursor_here;

  assign cur_nib     = 4'(currentRow >> {dig_idx_q, 2'b00});
  assign cursor_here = currentNum[dig_idx_q];

  hex_to_sevenseg u_dec (
    .val_i (cur_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    scan_cnt_d  = scan_cnt_q + ScanW'(1);
    dig_idx_d   = dig_idx_q;
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_ph_d  = blink_ph_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 2'd1;
    end
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (noWrite) begin
      err_cnt_d = ErrLoad;
    end else if (err_cnt_q != '0) begin
      err_cnt_d = err_cnt_q - ErrW'(1);
    end
    // The live noWrite term lets the LED rise one cycle after the request.
    err_led_d = noWrite | (err_cnt_q != '0);
  end

  always_comb begin
    an_d            = AN_OFF;
    an_d[dig_idx_q] = 1'b0;
    seg_d           = dec_seg;
    if (cursor_here && blink_ph_q) begin
      seg_d = SEG_BLANK;
    end
`ifdef DISPLAY_DP_CURSOR_EN
    dp_d = ~cursor_here;
`else
    dp_d = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      dig_idx_q   <= '0;
      err_cnt_q   <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      err_led_q   <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      dig_idx_q   <= dig_idx_d;
      err_cnt_q   <= err_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      err_led_q   <= err_led_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign errLed = err_led_q;

endmodule

// File: tb/tb_sevenseg_display_driver.sv
// Directed self-checking bench for sevenseg_display_driver (SCAN_DIV=4, BLINK_DIV=16, ERR_HOLD=5).
module tb_sevenseg_display_driver;

  logic        clk;
  logic        rst;
  logic [15:0] row;
  logic [3:0]  num;
  logic        no_write;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err_led;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sevenseg_display_driver #(
    .SCAN_DIV  (4),
    .BLINK_DIV (16),
    .ERR_HOLD  (5)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .currentRow (row),
    .currentNum (num),
    .noWrite    (no_write),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .errLed     (err_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; cyc counts edges since reset was released.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".an"},  16'(an),      16'hF);
    check_eq({tag, ".seg"}, 16'(seg),     16'h7F);
    check_eq({tag, ".dp"},  16'(dp),      16'h1);
    check_eq({tag, ".err"}, 16'(err_led), 16'h0);
  endtask

  // Expected display from the cycle count: digit advances every 4 cycles,
  // blink phase flips every 16 cycles, both starting at the first edge after reset.
  task automatic check_disp(input string tag);
    int         d;
    int         ph;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    d   = ((cyc - 1) / 4) % 4;
    ph  = ((cyc - 1) / 16) % 2;
    nib = row[4*d +: 4];
    ea  = 4'hF;
    ea[d] = 1'b0;
    es  = (nib == 4'h0 || (num[d] && ph == 1)) ? 7'h7F : seg_of(nib);
`ifdef DISPLAY_DP_CURSOR_EN
    ed  = ~num[d];
`else
    ed  = 1'b1;
`endif
    check_eq({tag, ".an"},  16'(an),  16'(ea));
    check_eq({tag, ".seg"}, 16'(seg), 16'(es));
    check_eq({tag, ".dp"},  16'(dp),  16'(ed));
  endtask

  initial begin
    rst      = 1'b1;
    row      = 16'h4321;
    num      = 4'b0000;
    no_write = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");

    rst = 1'b0;
    check_reset_vals("rel0");

    // Plain scan: 1,2,3,4 on digits 0..3, 4 cycles each.
    for (int k = 0; k < 16; k++) begin
      tick();
      check_disp("scan");
    end

    // Blank cells keep their anode enabled.
    row = 16'h0A0F;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_disp("blank");
    end

    // Cursor on digit 2 shown for 16 cycles, then blanked for 16.
    row = 16'h8888;
    num = 4'b0100;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_disp("blink");
    end

    // Cursor on an empty digit 0; dp marks it in both phases when enabled.
    row = 16'h0000;
    num = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_disp("dpcur");
    end

    // Single-cycle noWrite: LED high for 6 cycles.
    row = 16'h4321;
    num = 4'b0000;
    for (int k = 0; k < 9; k++) begin
      no_write = (k == 0);
      tick();
      check_eq("err1", 16'(err_led), 16'(k < 6));
      check_disp("err1d");
    end
    no_write = 1'b0;

    // Second pulse during the hold extends it 5 cycles past itself.
    for (int k = 0; k < 12; k++) begin
      no_write = (k == 0 || k == 3);
      tick();
      check_eq("err2", 16'(err_led), 16'(k <= 8));
    end
    no_write = 1'b0;

    // Reset mid-frame with the LED lit.
    tick();
    no_write = 1'b1;
    tick();
    no_write = 1'b0;
    tick();
    check_eq("prerst.err", 16'(err_led), 16'h1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    check_reset_vals("midrel0");
    for (int k = 0; k < 8; k++) begin
      tick();
      check_disp("after");
      check_eq("after.err", 16'(err_led), 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
